// File: rtl/pmod_dac_streamer.sv
// Parallel R-2R DAC driver: fixed-rate sample timer fed by a stream FIFO
// or a phase-accumulator generator (sawtooth, triangle, square).
module pmod_dac_streamer #(
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int CLKS_PER_SAMPLE = 25,
  parameter logic [DATA_WIDTH-1:0] IDLE_CODE =
    {1'b1, {(DATA_WIDTH-1){1'b0}}}
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_L,
  input  logic                          i_Enable,
  input  logic [1:0]                    i_Mode,
  input  logic [DATA_WIDTH-1:0]         i_Step,
  input  logic [DATA_WIDTH-1:0]         i_Data,
  input  logic                          i_Data_Valid,
  output logic                          o_Data_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic [DATA_WIDTH-1:0]         o_DAC_Data,
  output logic                          o_Sample_Strobe,
  output logic                          o_Underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_SAMPLE);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_SAMPLE - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] ONES = '1;

  typedef enum logic [1:0] {
    M_STREAM = 2'b00,
    M_SAW    = 2'b01,
    M_TRI    = 2'b10,
    M_SQR    = 2'b11
  } mode_e;

  mode_e mode;
  assign mode = mode_e'(i_Mode);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [DATA_WIDTH-1:0] phase_q, phase_d;
  logic [DATA_WIDTH-1:0] tri_q, tri_d;
  logic                  tri_dn_q, tri_dn_d;
  logic [DATA_WIDTH-1:0] dac_q, dac_d;
  logic                  stb_q, stb_d;
  logic                  und_q, und_d;

  logic                  push, pop, evt;
  logic [DATA_WIDTH-1:0] phase_nx;
  logic [DATA_WIDTH:0]   tri_sum;

  assign o_Data_Ready    = (count_q < DEPTH_C);
  assign o_Fifo_Count    = count_q;
  assign o_DAC_Data      = dac_q;
  assign o_Sample_Strobe = stb_q;
  assign o_Underrun      = und_q;

  assign push = i_Data_Valid && o_Data_Ready;
  assign evt  = i_Enable && (timer_q == T_LAST);
  assign pop  = evt && (mode == M_STREAM) && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    timer_d  = timer_q;
    phase_d  = phase_q;
    tri_d    = tri_q;
    tri_dn_d = tri_dn_q;
    dac_d    = dac_q;
    stb_d    = evt;
    und_d    = und_q;
    phase_nx = phase_q + i_Step;
    tri_sum  = {1'b0, tri_q} + {1'b0, i_Step};

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    if (!i_Enable) begin
      timer_d  = '0;
      phase_d  = '0;
      tri_d    = '0;
      tri_dn_d = 1'b0;
      dac_d    = IDLE_CODE;
      und_d    = 1'b0;
    end else begin
      timer_d = evt ? '0 : timer_q + TW'(1);
      if (evt) begin
        unique case (mode)
          M_STREAM: begin
            if (count_q != '0) dac_d = mem_q[rd_ptr_q];
            else               und_d = 1'b1;
          end
          M_SAW: begin
            phase_d = phase_nx;
            dac_d   = phase_nx;
          end
          M_SQR: begin
            phase_d = phase_nx;
            dac_d   = phase_nx[DATA_WIDTH-1] ? ONES : '0;
          end
          M_TRI: begin
            phase_d = phase_nx;
            // Saturate at either rail and turn around there.
            if (!tri_dn_q) begin
              if (tri_sum >= {1'b0, ONES}) begin
                tri_d    = ONES;
                tri_dn_d = 1'b1;
              end else begin
                tri_d = tri_sum[DATA_WIDTH-1:0];
              end
            end else if (tri_q <= i_Step) begin
              tri_d    = '0;
              tri_dn_d = 1'b0;
            end else begin
              tri_d = tri_q - i_Step;
            end
            dac_d = tri_d;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (push) mem_q[wr_ptr_q] <= i_Data;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      phase_q  <= '0;
      tri_q    <= '0;
      tri_dn_q <= 1'b0;
      dac_q    <= IDLE_CODE;
      stb_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      phase_q  <= phase_d;
      tri_q    <= tri_d;
      tri_dn_q <= tri_dn_d;
      dac_q    <= dac_d;
      stb_q    <= stb_d;
      und_q    <= und_d;
    end
  end

endmodule

// File: tb/tb_pmod_dac_streamer.sv
// Directed bench for pmod_dac_streamer: stream FIFO, generators,
// timing of sample strobes and reset behaviour.
module tb_pmod_dac_streamer;

  localparam int DW  = 8;
  localparam int FD  = 4;
  localparam int CPS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    mode;
  logic [DW-1:0] step;
  logic [DW-1:0] din;
  logic          dv;
  logic          ready;
  logic [2:0]    cnt;
  logic [DW-1:0] dac;
  logic          stb;
  logic          und;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pmod_dac_streamer #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(FD),
    .CLKS_PER_SAMPLE(CPS)
  ) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_n),
    .i_Enable(en),
    .i_Mode(mode),
    .i_Step(step),
    .i_Data(din),
    .i_Data_Valid(dv),
    .o_Data_Ready(ready),
    .o_Fifo_Count(cnt),
    .o_DAC_Data(dac),
    .o_Sample_Strobe(stb),
    .o_Underrun(und)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expects no strobe on the first CPS-1 edges, then one with value exp.
  task automatic sample(input string tag, input logic [DW-1:0] exp);
    cyc(CPS - 1);
    chk({tag, "_nostb"}, stb, 1'b0);
    cyc(1);
    chk({tag, "_stb"}, stb, 1'b1);
    chk(tag, dac, exp);
  endtask

  task automatic wr(input logic [DW-1:0] v);
    din = v;
    dv  = 1'b1;
    cyc(1);
    dv  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] saw [5];
    logic [DW-1:0] sqr [4];
    logic [DW-1:0] trv [7];
    saw = '{8'h40, 8'h80, 8'hC0, 8'h00, 8'h40};
    sqr = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    trv = '{8'h60, 8'hC0, 8'hFF, 8'h9F, 8'h3F, 8'h00, 8'h60};

    rst_n = 1'b0; en = 1'b0; mode = 2'b00;
    step = '0; din = '0; dv = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    chk("rst_dac", dac, 8'h80);
    chk("rst_cnt", cnt, 3'd0);
    chk("rst_rdy", ready, 1'b1);
    chk("rst_und", und, 1'b0);
    chk("rst_stb", stb, 1'b0);

    wr(8'h10); wr(8'h20); wr(8'h30);
    chk("st_cnt3", cnt, 3'd3);
    en = 1'b1;
    sample("st0", 8'h10);
    sample("st1", 8'h20);
    sample("st2", 8'h30);
    chk("st_cnt0", cnt, 3'd0);
    chk("st_und0", und, 1'b0);
    sample("st_hold", 8'h30);
    chk("st_und1", und, 1'b1);
    en = 1'b0;
    cyc(1);
    chk("dis_und", und, 1'b0);
    chk("dis_dac", dac, 8'h80);

    for (int i = 1; i <= 6; i++) wr(DW'(i));
    chk("full_cnt", cnt, 3'd4);
    chk("full_rdy", ready, 1'b0);
    en = 1'b1;
    sample("full0", 8'd1);
    sample("full1", 8'd2);
    sample("full2", 8'd3);
    sample("full3", 8'd4);
    chk("full_rdy2", ready, 1'b1);
    en = 1'b0;
    cyc(1);
    chk("full_cnt0", cnt, 3'd0);

    wr(8'hA1); wr(8'hA2);
    chk("pp_cnt2", cnt, 3'd2);
    en = 1'b1;
    cyc(CPS - 1);
    din = 8'hA3; dv = 1'b1;
    cyc(1);
    dv = 1'b0;
    chk("pp_stb", stb, 1'b1);
    chk("pp_dac", dac, 8'hA1);
    chk("pp_cnt", cnt, 3'd2);
    sample("pp1", 8'hA2);
    sample("pp2", 8'hA3);
    chk("pp_und0", und, 1'b0);
    cyc(CPS - 1);
    din = 8'hB4; dv = 1'b1;
    cyc(1);
    dv = 1'b0;
    chk("pe_stb", stb, 1'b1);
    chk("pe_und", und, 1'b1);
    chk("pe_cnt", cnt, 3'd1);
    chk("pe_dac", dac, 8'hA3);
    en = 1'b0;
    cyc(1);

    mode = 2'b01; step = 8'h40; en = 1'b1;
    for (int i = 0; i < 5; i++) sample($sformatf("saw%0d", i), saw[i]);
    chk("saw_cnt", cnt, 3'd1);
    en = 1'b0;
    cyc(1);

    mode = 2'b11; en = 1'b1;
    for (int i = 0; i < 4; i++) sample($sformatf("sqr%0d", i), sqr[i]);
    en = 1'b0;
    cyc(1);

    mode = 2'b10; step = 8'h60; en = 1'b1;
    for (int i = 0; i < 7; i++) sample($sformatf("tri%0d", i), trv[i]);
    chk("tri_cnt", cnt, 3'd1);

    cyc(2);
    rst_n = 1'b0;
    cyc(1);
    chk("mrst_dac", dac, 8'h80);
    chk("mrst_cnt", cnt, 3'd0);
    chk("mrst_stb", stb, 1'b0);
    rst_n = 1'b1;
    en = 1'b0;
    cyc(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
